// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector with a per-register pending scoreboard for long-latency ops.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard #(
  parameter int unsigned MAX_LONG_INFLIGHT = 2,
  parameter int unsigned PERF_CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_is_long,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        long_wb_valid,
  input  logic [4:0]  long_wb_rd,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_if_id,
  output logic        bubble_id_ex,
  output logic [31:0] pending_mask,
  output logic [2:0]  long_inflight,
  output logic        sb_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_flush_cycles
`endif
);

  if (MAX_LONG_INFLIGHT < 1 || MAX_LONG_INFLIGHT > 7 || PERF_CNT_W < 1) begin : g_bad_param
    $error("hazard_scoreboard: parameter out of range");
  end

  logic        lu_haz, raw_haz, waw_haz, full_haz, haz;
  logic        issue, set_long, set_bit;
  logic [31:0] pending_d;
  logic [2:0]  inflight_d;

  always_comb begin
    lu_haz   = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    raw_haz  = id_valid && ((id_uses_rs1 && pending_mask[id_rs1]) ||
                            (id_uses_rs2 && pending_mask[id_rs2]));
    waw_haz  = id_valid && id_reg_write && (id_rd != 5'd0) && pending_mask[id_rd];
    full_haz = id_valid && id_is_long && (long_inflight == 3'(MAX_LONG_INFLIGHT));
    haz      = lu_haz | raw_haz | waw_haz | full_haz;
    issue    = id_valid && !haz && !ex_branch_taken;
    set_long = issue && id_is_long;
    set_bit  = set_long && id_reg_write && (id_rd != 5'd0);
  end

  // Branch flush outranks any stall: the wrong-path ID instruction is simply dropped.
  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    if (ex_branch_taken) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (haz) begin
      stall_if     = 1'b1;
      stall_id     = 1'b1;
      bubble_id_ex = 1'b1;
    end
  end

  // Clear before set so an issue and writeback to the same rd leaves the bit set.
  always_comb begin
    pending_d = pending_mask;
    if (long_wb_valid) pending_d[long_wb_rd] = 1'b0;
    if (set_bit)       pending_d[id_rd]      = 1'b1;
    pending_d[0] = 1'b0;

    inflight_d = long_inflight;
    if (set_long && !long_wb_valid)
      inflight_d = long_inflight + 3'd1;
    else if (!set_long && long_wb_valid && long_inflight != 3'd0)
      inflight_d = long_inflight - 3'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_mask  <= '0;
      long_inflight <= '0;
      sb_err        <= 1'b0;
    end else begin
      pending_mask  <= pending_d;
      long_inflight <= inflight_d;
      if (long_wb_valid && long_inflight == 3'd0) sb_err <= 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_cycles <= '0;
    end else begin
      if (stall_id && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (flush_if_id && perf_flush_cycles != '1)
        perf_flush_cycles <= perf_flush_cycles + 1'b1;
    end
  end
`endif

endmodule
